mul_issue_ctrl: RTL

Sequencing front end for the 32x32 signed shift-add multiplier core. Accepts operand pairs over a valid/ready stream, buffers them in a small FIFO, drives the core's level-sensitive start/operand interface one job at a time, captures the 64-bit product, and presents it on a valid/ready result stream. Sits directly upstream of, and wraps the result path of, the multiplier core.

---
 rtl/mul_pkg.sv | 16 +
 rtl/mul_op_fifo.sv | 59 +++++
 rtl/mul_issue_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the multiplier issue front end.
package mul_pkg;

  localparam int unsigned MUL_W      = 32;
  localparam int unsigned PROD_W     = 64;
  localparam int unsigned MUL_CYCLES = 33;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StCapt,
    StDone,
    StGap
  } mul_state_e;

endpackage

// File: rtl/mul_op_fifo.sv
// Synchronous operand FIFO with registered occupancy; pointers wrap modulo DEPTH.
module mul_op_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LvlW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; contents are only observable through valid pointers.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LvlW'(1);
        2'b01:   level <= level - LvlW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issues queued operand pairs to the shift-add multiplier core one job at a time
// and returns the captured product on a valid/ready stream.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CAP_DLY = 1,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MUL_W-1:0]         in_mlier,
  input  logic [MUL_W-1:0]         in_mcand,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PROD_W-1:0]        out_prodt,
  output logic                     mul_start,
  output logic [MUL_W-1:0]         mul_mlier,
  output logic [MUL_W-1:0]         mul_mcand,
  input  logic                     mul_valid,
  input  logic [PROD_W-1:0]        mul_prodt,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_timeout
);

  localparam int unsigned CapW  = $clog2(CAP_DLY + 2);
  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  mul_state_e        state;
  logic [CapW-1:0]   cap_cnt;
  logic [WdogW-1:0]  wdog;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [2*MUL_W-1:0] rd_data;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == StIdle) && !empty;

  mul_op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * MUL_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .wr_data ({in_mlier, in_mcand}),
    .pop     (pop),
    .rd_data (rd_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      cap_cnt     <= '0;
      wdog        <= '0;
      mul_start   <= 1'b0;
      mul_mlier   <= '0;
      mul_mcand   <= '0;
      out_valid   <= 1'b0;
      out_prodt   <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (pop) begin
            {mul_mlier, mul_mcand} <= rd_data;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            wdog      <= '0;
            state     <= StRun;
          end
        end
        StRun: begin
          if (mul_valid) begin
            cap_cnt <= CapW'(CAP_DLY);
            state   <= StCapt;
          end else if (wdog == WdogW'(TIMEOUT - 1)) begin
            // Core never answered: drop the job and let it clear during GAP.
            err_timeout <= 1'b1;
            mul_start   <= 1'b0;
            state       <= StGap;
          end else begin
            wdog <= wdog + WdogW'(1);
          end
        end
        StCapt: begin
          if (cap_cnt == '0) begin
            out_prodt <= mul_prodt;
            out_valid <= 1'b1;
            mul_start <= 1'b0;
            state     <= StDone;
          end else begin
            cap_cnt <= cap_cnt - CapW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StGap;
          end
        end
        StGap: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          mul_start <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= StIdle;
        end
      endcase
    end
  end

endmodule
